mips_multicycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit: a Moore state machine that sequences the shared single-ALU datapath across fetch, decode, execute, memory and writeback cycles. It drives every datapath mux select, including the 3-to-1 `pc_source` mux, plus all write enables and the ALU operation. It sits between the instruction register's opcode/funct fields and the datapath, and stalls on a memory ready handshake.

---
 rtl/mips_multicycle_ctrl_if.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle MIPS control unit.
// master = control unit (drives mux selects and enables), slave = datapath.
// No storage. Signals are plain wires between the two sides.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
           mem_to_reg, instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
           mem_to_reg, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a shared-ALU multi-cycle MIPS datapath.
// Latency: R/sw/addi 4, lw 5, beq/bne/j 3 cycles; outputs are combinational from state.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold (request asserted, no enables) while mem_ready=0.
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rstb,
  mips_multicycle_ctrl_if.master bus
);

  // ALU operation encodings (classic MIPS ALU control values).
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCS_ALU  = 2'd0;
  localparam logic [1:0] PCS_OUT  = 2'd1;
  localparam logic [1:0] PCS_JMP  = 2'd2;

  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_EXEC, S_ADDI_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_active is low for the first cycle after reset release so the first
  // FETCH starts only after an edge has been seen with rstb high.
  logic r_active;
  logic w_gate;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_i_or_d;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_source;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu_control;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_instr_done;
  logic       w_illegal_op;

  logic       w_funct_ok;
  logic [3:0] w_funct_op;

  // R-type funct to ALU operation; shared by EXECUTE and ALU_WB since funct
  // stays stable for the whole instruction.
  always_comb begin
    w_funct_ok = 1'b1;
    w_funct_op = ALU_ADD;
    case (bus.funct)
      6'b100000: w_funct_op = ALU_ADD;
      6'b100010: w_funct_op = ALU_SUB;
      6'b100100: w_funct_op = ALU_AND;
      6'b100101: w_funct_op = ALU_OR;
      6'b100110: w_funct_op = ALU_XOR;
      6'b100111: w_funct_op = ALU_NOR;
      6'b101010: w_funct_op = ALU_SLT;
      default: begin
        w_funct_ok = 1'b0;
        w_funct_op = ALU_ADD;
      end
    endcase
  end

  // State register; any reset edge returns to FETCH, abandoning the instruction.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= S_FETCH;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      r_state  <= r_active ? w_next : S_FETCH;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next        = r_state;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_i_or_d      = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_source   = PCS_ALU;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = SRCB_B;
    w_alu_control = 4'h0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_instr_done  = 1'b0;
    w_illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        w_alu_src_b   = SRCB_4;
        w_alu_control = ALU_ADD;
        w_pc_source   = PCS_ALU;
        w_ir_write    = bus.mem_ready;
        w_pc_write    = bus.mem_ready;
        w_next        = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut <= PC + (imm << 2): branch target precomputed here.
        w_alu_src_b   = SRCB_BR;
        w_alu_control = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:      w_next = S_EXECUTE;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = S_ADDI_EXEC;
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
            w_instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = SRCB_IMM;
        w_alu_control = ALU_ADD;
        w_next        = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        w_next     = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_write  = 1'b1;
        w_i_or_d     = 1'b1;
        w_instr_done = bus.mem_ready;
        w_next       = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = SRCB_B;
        w_alu_control = w_funct_op;
        if (w_funct_ok) begin
          w_next = S_ALU_WB;
        end else begin
          w_illegal_op = 1'b1;
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_ALU_WB: begin
        w_alu_control = w_funct_op;
        w_reg_write   = 1'b1;
        w_reg_dst     = 1'b1;
        w_instr_done  = 1'b1;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = SRCB_B;
        w_alu_control = ALU_SUB;
        w_pc_source   = PCS_OUT;
        w_pc_write    = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
        w_instr_done  = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        w_pc_source  = PCS_JMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDI_EXEC: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = SRCB_IMM;
        w_alu_control = ALU_ADD;
        w_next        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Outputs are held at zero while reset is asserted and for the release cycle,
  // so a reset in the middle of a memory write drops the request at once.
  assign w_gate = rstb & r_active;

  assign bus.mem_read    = w_gate & w_mem_read;
  assign bus.mem_write   = w_gate & w_mem_write;
  assign bus.i_or_d      = w_gate & w_i_or_d;
  assign bus.ir_write    = w_gate & w_ir_write;
  assign bus.pc_write    = w_gate & w_pc_write;
  assign bus.pc_source   = w_gate ? w_pc_source : 2'd0;
  assign bus.alu_src_a   = w_gate & w_alu_src_a;
  assign bus.alu_src_b   = w_gate ? w_alu_src_b : 2'd0;
  assign bus.alu_control = w_gate ? w_alu_control : 4'h0;
  assign bus.reg_write   = w_gate & w_reg_write;
  assign bus.reg_dst     = w_gate & w_reg_dst;
  assign bus.mem_to_reg  = w_gate & w_mem_to_reg;
  assign bus.instr_done  = w_gate & w_instr_done;
  assign bus.illegal_op  = w_gate & w_illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected output vectors are queued
// as each cycle's stimulus is driven, then popped and compared mid-cycle.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] SUB = 4'h6;
  localparam logic [3:0] AND = 4'h0;
  localparam logic [3:0] OR  = 4'h1;
  localparam logic [3:0] XOR = 4'h3;
  localparam logic [3:0] NOR = 4'hC;
  localparam logic [3:0] SLT = 4'h7;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  logic clk;
  logic rstb;
  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  out_t sb[$];

  // Expected vectors per state, written from the state output table.
  function automatic out_t e_zero();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t e_fetch(input logic mr);
    out_t o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'd1; o.alu_control = ADD;
    o.ir_write = mr;   o.pc_write = mr;
    return o;
  endfunction
  function automatic out_t e_decode(input logic ill);
    out_t o = '0;
    o.alu_src_b = 2'd3; o.alu_control = ADD;
    o.illegal_op = ill; o.instr_done = ill;
    return o;
  endfunction
  function automatic out_t e_memaddr();
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_control = ADD;
    return o;
  endfunction
  function automatic out_t e_memread();
    out_t o = '0;
    o.mem_read = 1'b1; o.i_or_d = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memwb();
    out_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memwrite(input logic mr);
    out_t o = '0;
    o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = mr;
    return o;
  endfunction
  function automatic out_t e_exec(input logic [3:0] op, input logic ill);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_control = op;
    o.illegal_op = ill; o.instr_done = ill;
    return o;
  endfunction
  function automatic out_t e_aluwb(input logic [3:0] op);
    out_t o = '0;
    o.alu_control = op; o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t e_branch(input logic pcw);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_control = SUB; o.pc_source = 2'd1;
    o.pc_write = pcw; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t e_jump();
    out_t o = '0;
    o.pc_source = 2'd2; o.pc_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t e_addiwb();
    out_t o = '0;
    o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.mem_read    = bus.mem_read;
    o.mem_write   = bus.mem_write;
    o.i_or_d      = bus.i_or_d;
    o.ir_write    = bus.ir_write;
    o.pc_write    = bus.pc_write;
    o.pc_source   = bus.pc_source;
    o.alu_src_a   = bus.alu_src_a;
    o.alu_src_b   = bus.alu_src_b;
    o.alu_control = bus.alu_control;
    o.reg_write   = bus.reg_write;
    o.reg_dst     = bus.reg_dst;
    o.mem_to_reg  = bus.mem_to_reg;
    o.instr_done  = bus.instr_done;
    o.illegal_op  = bus.illegal_op;
    return o;
  endfunction

  // One cycle: queue the expected vector for the inputs just driven, sample
  // at the falling edge, compare against the queue head, then advance to
  // 1 time unit past the next rising edge.
  task automatic cyc(input string tag, input out_t e);
    out_t obs;
    out_t exp_v;
    sb.push_back(e);
    @(negedge clk);
    obs   = observed();
    exp_v = sb.pop_front();
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [7];
  logic [3:0] op_tab [7];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    op_tab = '{ADD, SUB, AND, OR, XOR, NOR, SLT};

    rstb = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: every output is 0, even with mem_ready high.
    cyc("rst0", e_zero());
    cyc("rst1", e_zero());
    cyc("rst2", e_zero());
    rstb = 1'b1;
    cyc("rst_release", e_zero());
    // A stall in FETCH suppresses ir_write/pc_write.
    bus.mem_ready = 1'b0;
    cyc("fetch_stall", e_fetch(1'b0));
    bus.mem_ready = 1'b1;

    // R-type sub.
    bus.opcode = 6'b000000; bus.funct = 6'b100010;
    cyc("r_fetch", e_fetch(1'b1));
    cyc("r_decode", e_decode(1'b0));
    cyc("r_exec_sub", e_exec(SUB, 1'b0));
    cyc("r_wb_sub", e_aluwb(SUB));

    // Remaining funct mappings.
    for (int k = 0; k < 7; k++) begin
      bus.funct = fn_tab[k];
      cyc("rk_fetch", e_fetch(1'b1));
      cyc("rk_decode", e_decode(1'b0));
      cyc("rk_exec", e_exec(op_tab[k], 1'b0));
      cyc("rk_wb", e_aluwb(op_tab[k]));
    end

    // Unsupported funct: ADD, illegal pulse, straight back to FETCH.
    bus.funct = 6'b000000;
    cyc("badf_fetch", e_fetch(1'b1));
    cyc("badf_decode", e_decode(1'b0));
    cyc("badf_exec", e_exec(ADD, 1'b1));

    // lw with two stall cycles in MEM_READ (7 cycles).
    bus.opcode = 6'b100011;
    cyc("lw_fetch", e_fetch(1'b1));
    cyc("lw_decode", e_decode(1'b0));
    cyc("lw_addr", e_memaddr());
    bus.mem_ready = 1'b0;
    cyc("lw_stall0", e_memread());
    cyc("lw_stall1", e_memread());
    bus.mem_ready = 1'b1;
    cyc("lw_read", e_memread());
    cyc("lw_wb", e_memwb());

    // sw, no stall.
    bus.opcode = 6'b101011;
    cyc("sw_fetch", e_fetch(1'b1));
    cyc("sw_decode", e_decode(1'b0));
    cyc("sw_addr", e_memaddr());
    cyc("sw_write", e_memwrite(1'b1));

    // Branches: beq/bne with zero both ways.
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    cyc("beq1_fetch", e_fetch(1'b1));
    cyc("beq1_decode", e_decode(1'b0));
    cyc("beq_z1", e_branch(1'b1));
    bus.zero = 1'b0;
    cyc("beq0_fetch", e_fetch(1'b1));
    cyc("beq0_decode", e_decode(1'b0));
    cyc("beq_z0", e_branch(1'b0));
    bus.opcode = 6'b000101; bus.zero = 1'b1;
    cyc("bne1_fetch", e_fetch(1'b1));
    cyc("bne1_decode", e_decode(1'b0));
    cyc("bne_z1", e_branch(1'b0));
    bus.zero = 1'b0;
    cyc("bne0_fetch", e_fetch(1'b1));
    cyc("bne0_decode", e_decode(1'b0));
    cyc("bne_z0", e_branch(1'b1));

    // Jump.
    bus.opcode = 6'b000010;
    cyc("j_fetch", e_fetch(1'b1));
    cyc("j_decode", e_decode(1'b0));
    cyc("j_jump", e_jump());

    // addi.
    bus.opcode = 6'b001000;
    cyc("addi_fetch", e_fetch(1'b1));
    cyc("addi_decode", e_decode(1'b0));
    cyc("addi_exec", e_memaddr());
    cyc("addi_wb", e_addiwb());

    // Illegal opcode: pulse in DECODE, then FETCH.
    bus.opcode = 6'b111111;
    cyc("ill_fetch", e_fetch(1'b1));
    cyc("ill_decode", e_decode(1'b1));
    bus.opcode = 6'b000010;
    cyc("ill_next_fetch", e_fetch(1'b1));
    cyc("ill_next_decode", e_decode(1'b0));
    cyc("ill_next_jump", e_jump());

    // Reset during a stalled MEM_WRITE.
    bus.opcode = 6'b101011;
    cyc("rsw_fetch", e_fetch(1'b1));
    cyc("rsw_decode", e_decode(1'b0));
    cyc("rsw_addr", e_memaddr());
    bus.mem_ready = 1'b0;
    cyc("rsw_stall", e_memwrite(1'b0));
    rstb = 1'b0;
    cyc("rsw_rst0", e_zero());
    cyc("rsw_rst1", e_zero());
    rstb = 1'b1;
    cyc("rsw_release", e_zero());
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000010;
    cyc("rsw_fetch2", e_fetch(1'b1));
    cyc("rsw_decode2", e_decode(1'b0));
    cyc("rsw_jump2", e_jump());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
